// File: rtl/calc_op_sequencer_pkg.sv
// Shared types and constants for the calculator operation sequencer.
// State encoding, button bit positions, buffer mode values and a one-hot helper.
package calc_op_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP1,
        POP2,
        CAP2,
        EXEC,
        PUSH
    } state_t;

    localparam int BTN_PUSH  = 0;
    localparam int BTN_OP_LO = 1;
    localparam int BTN_OP_HI = 4;

    localparam logic MODE_STACK = 1'b1;
    localparam logic MODE_QUEUE = 1'b0;

    // Isolates the least-significant set bit, so the lowest button wins.
    function automatic logic [3:0] lowest_onehot(input logic [3:0] v);
        return v & (~v + 4'd1);
    endfunction

endpackage

// File: rtl/calc_op_sequencer_btn_edge.sv
// Rising-edge detector for the debounced button levels.
// Latency: edge is combinational against the previous-cycle level; no backpressure.
module btn_edge_detect #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] btn_i,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] btn_prev_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            btn_prev_q <= '0;
        end else begin
            btn_prev_q <= btn_i;
        end
    end

    assign rise_o = btn_i & ~btn_prev_q;

endmodule

// File: rtl/calc_op_sequencer.sv
// Pushes switch values and runs pop-pop-ALU-push operations against the stack/queue buffer.
// Operation: pops in cycles 1-2 after the op edge, result push in cycle 5; edges while busy are dropped.
module calc_op_sequencer
    import calc_op_sequencer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SW_W   = 16,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stackQueue,
    input  logic [SW_W-1:0]   switches,
    input  logic [4:0]        btn_db,
    input  logic [CNT_W-1:0]  mem_count,
    input  logic              mem_full,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_push,
    output logic              mem_pop,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_y,
    output logic [DATA_W-1:0] display,
    output logic              busy,
    output logic              err_full,
    output logic              err_under
);

    logic [4:0]        rise;
    logic [3:0]        op_rise;
    logic [DATA_W-1:0] sw_ext;
    logic              push_req;
    logic              push_ok;
    logic              op_req;
    logic              op_ok;

    state_t            state_q;
    state_t            state_d;
    logic              mode_q;
    logic [DATA_W-1:0] op1_q;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [3:0]        alu_op_q;
    logic [DATA_W-1:0] display_q;
    logic              err_full_q;
    logic              err_under_q;

    btn_edge_detect #(
        .W (5)
    ) u_btn_edge (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (btn_db),
        .rise_o (rise)
    );

    assign op_rise = rise[BTN_OP_HI:BTN_OP_LO];
    assign sw_ext  = DATA_W'(switches);

    always_comb begin
        push_req = (state_q == IDLE) && rise[BTN_PUSH];
        push_ok  = push_req && !mem_full;
        op_req   = (state_q == IDLE) && !rise[BTN_PUSH] && (|op_rise);
        op_ok    = op_req && (mem_count >= CNT_W'(2));

        // Strobes are gated by reset so an aborted operation touches the buffer no further.
        mem_push  = rst && (push_ok || (state_q == PUSH));
        mem_pop   = rst && ((state_q == POP1) || (state_q == POP2));
        mem_wdata = '0;
        if (mem_push) begin
            mem_wdata = (state_q == PUSH) ? result_q : sw_ext;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (op_ok) state_d = POP1;
            POP1:    state_d = POP2;
            POP2:    state_d = CAP2;
            CAP2:    state_d = EXEC;
            EXEC:    state_d = PUSH;
            PUSH:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            mode_q      <= MODE_QUEUE;
            op1_q       <= '0;
            result_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            display_q   <= '0;
            err_full_q  <= 1'b0;
            err_under_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (push_ok) begin
                        display_q   <= sw_ext;
                        err_full_q  <= 1'b0;
                        err_under_q <= 1'b0;
                    end else if (push_req) begin
                        err_full_q <= 1'b1;
                    end else if (op_ok) begin
                        alu_op_q <= lowest_onehot(op_rise);
                        mode_q   <= stackQueue;
                    end else if (op_req) begin
                        err_under_q <= 1'b1;
                    end
                end
                POP2: op1_q <= mem_rdata;
                CAP2: begin
                    // The first pop is the newer word in stack mode, the older one in queue mode.
                    if (mode_q == MODE_STACK) begin
                        alu_a_q <= mem_rdata;
                        alu_b_q <= op1_q;
                    end else begin
                        alu_a_q <= op1_q;
                        alu_b_q <= mem_rdata;
                    end
                end
                EXEC: result_q  <= alu_y;
                PUSH: display_q <= result_q;
                default: ;
            endcase
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign display   = display_q;
    assign busy      = (state_q != IDLE);
    assign err_full  = err_full_q;
    assign err_under = err_under_q;

endmodule
